// File: rtl/cnt_seq_ctrl_pkg.sv
// Shared definitions for the counter sequencer: state encodings and the
// default counter width it must agree with.
package cnt_seq_ctrl_pkg;

    localparam int CNT_WIDTH = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

endpackage

// File: rtl/cnt_seq_ctrl_if.sv
// Control/feedback bundle between the sequencer and its user plus the
// downstream loadable counter.
interface cnt_seq_ctrl_if
    import cnt_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH,
    parameter int PRE_W = 4,
    parameter int PER_W = 8
) ();

    logic             start;
    logic             stop;
    logic             oneshot;
    logic [WIDTH-1:0] start_val;
    logic [WIDTH-1:0] term_val;
    logic [PRE_W-1:0] prescale;
    logic [WIDTH-1:0] cnt_q;
    logic             cnt_load;
    logic             cnt_enab;
    logic [WIDTH-1:0] cnt_din;
    logic             busy;
    logic             done;
    logic [PER_W-1:0] periods;

    modport master (
        output start, stop, oneshot, start_val, term_val, prescale, cnt_q,
        input  cnt_load, cnt_enab, cnt_din, busy, done, periods
    );

    modport slave (
        input  start, stop, oneshot, start_val, term_val, prescale, cnt_q,
        output cnt_load, cnt_enab, cnt_din, busy, done, periods
    );

endinterface

// File: rtl/cnt_seq_ctrl_tick_prescaler.sv
// Free-running divider: tick is high once every pre_s+1 enabled cycles,
// starting pre_s cycles after a clear.
module cnt_seq_ctrl_tick_prescaler #(
    parameter int PRE_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [PRE_W-1:0] pre_s,
    output logic             tick
);

    logic [PRE_W-1:0] pre_cnt_q;
    logic [PRE_W-1:0] pre_cnt_d;

    assign tick = (pre_cnt_q == pre_s);

    always_comb begin
        pre_cnt_d = pre_cnt_q;
        if (clr) begin
            pre_cnt_d = '0;
        end else if (en) begin
            pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end

endmodule

// File: rtl/cnt_seq_ctrl.sv
// One-shot / periodic timer sequencer driving an external loadable counter:
// load start value, step at a prescaled rate, stop or reload at terminal.
module cnt_seq_ctrl
    import cnt_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = CNT_WIDTH,
    parameter int PRE_W = 4,
    parameter int PER_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    cnt_seq_ctrl_if.slave  bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] start_s_q, start_s_d;
    logic [WIDTH-1:0] term_s_q, term_s_d;
    logic [PRE_W-1:0] pre_s_q, pre_s_d;
    logic             os_s_q, os_s_d;
    logic             done_q, done_d;
    logic [PER_W-1:0] periods_q, periods_d;
    logic             tick;
    logic             at_term;

    assign at_term = (bus.cnt_q == term_s_q);

    cnt_seq_ctrl_tick_prescaler #(.PRE_W(PRE_W)) u_prescaler (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.stop || (state_q == ST_LOAD)),
        .en    (state_q == ST_RUN),
        .pre_s (pre_s_q),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        start_s_d = start_s_q;
        term_s_d  = term_s_q;
        pre_s_d   = pre_s_q;
        os_s_d    = os_s_q;
        done_d    = 1'b0;
        periods_d = periods_q;
        if (bus.stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        start_s_d = bus.start_val;
                        term_s_d  = bus.term_val;
                        pre_s_d   = bus.prescale;
                        os_s_d    = bus.oneshot;
                        periods_d = '0;
                        state_d   = ST_LOAD;
                    end
                end
                ST_LOAD: state_d = ST_RUN;
                ST_RUN: begin
                    // The counter holds at term because enab is masked here.
                    if (at_term) begin
                        done_d    = 1'b1;
                        periods_d = (&periods_q) ? periods_q : periods_q + 1'b1;
                        state_d   = os_s_q ? ST_IDLE : ST_LOAD;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            start_s_q <= '0;
            term_s_q  <= '0;
            pre_s_q   <= '0;
            os_s_q    <= 1'b0;
            done_q    <= 1'b0;
            periods_q <= '0;
        end else begin
            state_q   <= state_d;
            start_s_q <= start_s_d;
            term_s_q  <= term_s_d;
            pre_s_q   <= pre_s_d;
            os_s_q    <= os_s_d;
            done_q    <= done_d;
            periods_q <= periods_d;
        end
    end

    assign bus.cnt_load = (state_q == ST_LOAD);
    assign bus.cnt_enab = (state_q == ST_RUN) && tick && !at_term;
    assign bus.cnt_din  = start_s_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = done_q;
    assign bus.periods  = periods_q;

endmodule

// File: doc/cnt_seq_ctrl.md
Name: cnt_seq_ctrl

Overview:
- Sequencer FSM directly upstream of the loadable counter (clk, rst, load, enab, cnt_in, cnt_out).
- Drives the counter's load, enab and cnt_in, and watches the counter's cnt_out fed back on cnt_q.
- Implements a programmable one-shot or periodic timer: load a start value, increment at a prescaled rate, stop or reload at a terminal value, pulse done.

Parameters:
- WIDTH, 5: counter width; must match the downstream counter.
- PRE_W, 4: prescaler width.
- PER_W, 8: width of the completed-period counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- start  in  1  begin sequence; sampled only in IDLE
- stop  in  1  abort to IDLE from any state
- oneshot  in  1  1 = stop after one period, 0 = periodic reload
- start_val  in  WIDTH  counter load value
- term_val  in  WIDTH  terminal counter value
- prescale  in  PRE_W  enable every prescale+1 cycles
- cnt_q  in  WIDTH  counter output fed back
- cnt_load  out  1  to counter load
- cnt_enab  out  1  to counter enab
- cnt_din  out  WIDTH  to counter cnt_in
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse per completed period
- periods  out  PER_W  completed periods, saturating

Behaviour:
- Reset: state IDLE; shadow registers, pre_cnt, done and periods = 0. All outputs 0.
- States: IDLE, LOAD, RUN.
- IDLE, start=1, stop=0:
  - Latch start_val, term_val, prescale, oneshot into shadow regs (start_s, term_s, pre_s, os_s).
  - Clear periods. Next state LOAD.
  - start while busy is ignored; inputs are used only via shadow regs.
- LOAD:
  - cnt_load = 1 (combinational from state), cnt_din = start_s.
  - pre_cnt <= 0. Next state RUN unconditionally (unless stop).
- RUN:
  - cnt_enab = (pre_cnt == pre_s) && (cnt_q != term_s), combinational.
  - pre_cnt <= (pre_cnt == pre_s) ? 0 : pre_cnt + 1.
  - When cnt_q == term_s: enab is suppressed, so the counter holds at term.
    - Register done <= 1 for exactly one cycle.
    - periods <= periods + 1, saturating at all-ones.
    - Next state: IDLE if os_s, else LOAD.
- cnt_din = start_s in every state; cnt_load and cnt_enab are 0 outside their states.
- Timing, with start accepted in cycle 0, N = (term_s - start_s) mod 2^WIDTH, P = pre_s:
  - cnt_q = start_s + n at cycle 2 + n(P+1).
  - Terminal detected at cycle 2 + N(P+1); done high in cycle 3 + N(P+1).
  - Periodic period = N(P+1) + 2 cycles.
- Wrap-around: term_s < start_s is legal. The counter passes through 2^WIDTH-1 to 0, with no special handling.
- start_val == term_val: N = 0, done in cycle 3, periodic period of 2 cycles.
- stop (priority below rst, above all else): next state IDLE from any state, no done pulse, periods retained, pre_cnt cleared.
- start and stop together in IDLE: stop wins, stays IDLE.
- rst mid-operation: everything returns to reset values next cycle.
- The counter itself is reset by the same rst; this block does not drive counter reset.

Decomposition:
- Shared package/include: state encodings (IDLE=2'd0, LOAD=2'd1, RUN=2'd2) and the default WIDTH, shared with the counter.
- One natural sub-module: tick_prescaler.
  - Inputs: clk, rst, clr, en, pre_s.
  - Output: tick = (pre_cnt == pre_s).
- The bench instantiates cnt_seq_ctrl wired to the existing counter in a closed loop.

Test Plan:
- rst held 3 cycles with start=1 -> busy=0, done=0, cnt_load=0, cnt_enab=0, periods=0 throughout.
- WIDTH=5, start_val=3, term_val=7, prescale=0, oneshot=1, start pulse at cycle 0 -> cnt_load high in cycle 1; cnt_q=3,4,5,6,7 at cycles 2..6; done in cycle 7; IDLE in cycle 7; periods=1.
- Same with prescale=2 -> cnt_enab high only at cycles 4,7,10,13; done in cycle 15; cnt_q holds 7 afterwards.
- start_val=30, term_val=1, prescale=0, oneshot=0 -> cnt_q 30,31,0,1; reload each 5 cycles; done every 5 cycles; after 3 periods periods=3.
- stop asserted at cycle 4 of the previous scenario -> IDLE at cycle 5, no done, cnt_enab=0, periods unchanged.
- start_val=term_val=9, oneshot=0, run 300 periods with PER_W=8 -> done every 2 cycles; periods saturates at 255.
